instr_mem_fetch: RTL and testbench

Parametrised instruction memory with a valid/ready fetch interface, sitting between the PC/fetch stage and the instruction decoder. It takes a byte-addressed PC, returns the 32-bit instruction word one cycle later through a 2-entry response buffer, and flags misaligned or out-of-range fetches. A write port lets the loader or testbench program the memory at run time; a flush input discards buffered responses on a branch redirect.

---
 rtl/instr_mem_fetch_if.sv | 26 ++
 rtl/instr_mem_fetch.sv | 114 +++++++++++
 tb/tb_instr_mem_fetch.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_fetch_if.sv
// Fetch-side bus of the instruction memory: request channel (PC in) and
// response channel (instruction word out), both valid/ready.
//   req_valid / req_ready / req_addr               : fetch request, byte address
//   rsp_valid / rsp_ready / rsp_instr / rsp_addr /
//   rsp_fault                                      : head of the response buffer
// master = fetch stage / consumer side, slave = instruction memory.
interface instr_mem_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Instruction memory with a valid/ready fetch port and a 2-entry response
// buffer. A fetch accepted at one edge is presented on rsp_* in the next
// cycle. Misaligned or out-of-range fetches return NOP_WORD with rsp_fault.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (slave)           : request/response handshake bus
//   flush                 : drop every buffered response at the next edge
//   prog_we/addr/data     : run-time program write port (word indexed)
module instr_mem_fetch #(
  parameter int          DEPTH    = 64,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_fetch_if.slave  bus,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [31:0]       prog_data
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  // Memory image is deliberately outside the reset domain so a reset
  // during operation keeps the loaded program.
  logic [31:0] mem_q [DEPTH] = '{default: NOP_WORD};

  logic [31:0] ent_instr_q [2];
  logic [31:0] ent_instr_d [2];
  logic [31:0] ent_addr_q  [2];
  logic [31:0] ent_addr_d  [2];
  logic        ent_fault_q [2];
  logic        ent_fault_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q,  count_d;

  logic          push;
  logic          pop;
  logic          req_fault;
  logic [AW-1:0] req_idx;
  logic [31:0]   req_word;

  always_ff @(posedge clk) begin
    if (prog_we && ({{(32-AW){1'b0}}, prog_addr} < DEPTH_W)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // req_ready depends only on registered state and prog_we, never on
  // rsp_ready, so there is no combinational path through the buffer.
  assign bus.req_ready = !prog_we && (count_q != 2'd2);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign req_fault = (bus.req_addr[1:0] != 2'b00) ||
                     ({2'b00, bus.req_addr[31:2]} >= DEPTH_W);
  assign req_idx   = bus.req_addr[AW+1:2];
  // The array read is only used when the index is in range.
  assign req_word  = req_fault ? NOP_WORD : mem_q[req_idx];

  always_comb begin
    ent_instr_d = ent_instr_q;
    ent_addr_d  = ent_addr_q;
    ent_fault_d = ent_fault_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (push) begin
      ent_instr_d[wr_ptr_q] = req_word;
      ent_addr_d[wr_ptr_q]  = bus.req_addr;
      ent_fault_d[wr_ptr_q] = req_fault;
      wr_ptr_d              = ~wr_ptr_q;
    end

    if (flush) begin
      // Everything already buffered is dropped; a request accepted in the
      // same cycle lands at wr_ptr_q and becomes the new head.
      rd_ptr_d = wr_ptr_q;
      count_d  = push ? 2'd1 : 2'd0;
    end else begin
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_instr_q <= '{default: '0};
      ent_addr_q  <= '{default: '0};
      ent_fault_q <= '{default: 1'b0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      ent_instr_q <= ent_instr_d;
      ent_addr_q  <= ent_addr_d;
      ent_fault_q <= ent_fault_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign bus.rsp_valid = (count_q != 2'd0);
  assign bus.rsp_instr = ent_instr_q[rd_ptr_q];
  assign bus.rsp_addr  = ent_addr_q[rd_ptr_q];
  assign bus.rsp_fault = ent_fault_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_mem_fetch.sv
module tb_instr_mem_fetch;

  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;

  instr_mem_fetch_if bus_if();

  instr_mem_fetch #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } rsp_t;

  rsp_t        sb_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: on each accepted request, the expected response is
  // derived from the architectural rules and queued.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (flush) sb_q.delete();
      if (bus_if.req_valid && bus_if.req_ready) begin
        rsp_t        e;
        logic [31:0] a;
        a       = bus_if.req_addr;
        e.addr  = a;
        e.fault = (a % 4 != 0) || (a / 4 >= DEPTH);
        e.instr = e.fault ? NOP : ref_mem[a / 4];
        sb_q.push_back(e);
      end
      if (prog_we) ref_mem[prog_addr] = prog_data;
    end
  end

  // Monitor: compares the presented head against the scoreboard.
  always begin
    @(negedge clk);
    if (rst_n) begin
      chk("rsp_valid", {31'b0, bus_if.rsp_valid}, {31'b0, sb_q.size() != 0});
      chk("req_ready", {31'b0, bus_if.req_ready}, {31'b0, (!prog_we && sb_q.size() < 2)});
      if (bus_if.rsp_valid && sb_q.size() != 0) begin
        chk("rsp_instr", bus_if.rsp_instr, sb_q[0].instr);
        chk("rsp_addr",  bus_if.rsp_addr,  sb_q[0].addr);
        chk("rsp_fault", {31'b0, bus_if.rsp_fault}, {31'b0, sb_q[0].fault});
        if (bus_if.rsp_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until it is accepted (bounded).
  task automatic fetch(input logic [31:0] a);
    logic rdy;
    bit   done;
    done = 0;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = a;
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = bus_if.req_ready;
      cyc();
      if (rdy) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL fetch_timeout: got no accept expected accept for addr %h", a);
    end
    bus_if.req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    rst_n            = 1'b0;
    flush            = 1'b0;
    prog_we          = 1'b0;
    prog_addr        = '0;
    prog_data        = '0;
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
    chk("rst_rsp_instr", bus_if.rsp_instr, 32'd0);
    chk("rst_rsp_addr",  bus_if.rsp_addr,  32'd0);
    chk("rst_rsp_fault", {31'b0, bus_if.rsp_fault}, 32'd0);
    chk("rst_req_ready", {31'b0, bus_if.req_ready}, 32'd1);
    cyc();

    // Back-to-back fetches with the consumer always ready.
    bus_if.rsp_ready = 1'b1;
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    repeat (2) cyc();

    // Program write then fetch of the written word.
    prog_we   = 1'b1;
    prog_addr = 6'd3;
    prog_data = 32'h0091_0833;
    cyc();
    prog_we = 1'b0;
    fetch(32'hC);
    repeat (2) cyc();

    // Faulting fetches: misaligned and out of range.
    fetch(32'h2);
    fetch(32'h100);
    repeat (2) cyc();

    // Backpressure: two accepted, third waits for the first pop.
    bus_if.rsp_ready = 1'b0;
    fetch(32'h0);
    fetch(32'h4);
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 32'h8;
    repeat (3) cyc();
    chk("bp_req_ready", {31'b0, bus_if.req_ready}, 32'd0);
    chk("bp_head_addr", bus_if.rsp_addr, 32'h0);
    bus_if.rsp_ready = 1'b1;
    fetch(32'h8);
    repeat (3) cyc();

    // Flush of a full buffer with a request held on the bus.
    bus_if.rsp_ready = 1'b0;
    fetch(32'h14);
    fetch(32'h18);
    flush            = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 32'h10;
    cyc();
    flush = 1'b0;
    chk("flush_full_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
    cyc();
    bus_if.req_valid = 1'b0;
    chk("flush_full_head", bus_if.rsp_addr, 32'h10);

    // Flush with one buffered entry and a concurrently accepted request.
    flush            = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 32'h2C;
    cyc();
    flush            = 1'b0;
    bus_if.req_valid = 1'b0;
    chk("flush_one_head", bus_if.rsp_addr, 32'h2C);
    bus_if.rsp_ready = 1'b1;
    repeat (2) cyc();

    // Asynchronous reset with two buffered entries.
    bus_if.rsp_ready = 1'b0;
    fetch(32'h20);
    fetch(32'h24);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
    chk("async_rst_addr",  bus_if.rsp_addr, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, bus_if.req_ready}, 32'd1);
    cyc();
    bus_if.rsp_ready = 1'b1;
    fetch(32'hC);
    repeat (2) cyc();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      bus_if.req_valid = 1'($urandom_range(0, 1));
      if (r < 7)       bus_if.req_addr = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (r == 7) bus_if.req_addr = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
      else if (r == 8) bus_if.req_addr = {22'($urandom_range(1, 1000)), 8'd0, 2'b00};
      else             bus_if.req_addr = $urandom;
      bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
      flush            = ($urandom_range(0, 15) == 0);
      prog_we          = ($urandom_range(0, 7) == 0);
      prog_addr        = 6'($urandom);
      prog_data        = $urandom;
      cyc();
    end

    bus_if.req_valid = 1'b0;
    flush            = 1'b0;
    prog_we          = 1'b0;
    bus_if.rsp_ready = 1'b1;
    repeat (4) cyc();
    chk("drain_valid", {31'b0, bus_if.rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
